sr_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one bank of NFLAGS set/reset flags between NREQ requesters. Each requester issues S/R commands against a flag index over a req/gnt handshake. The block applies at most one command per cycle to the bank and exposes every flag as q/q_bar. It is the sequencing layer above our single SR flip-flop: flag semantics match that cell, and arbitration, handshaking and illegal-command handling live here.

---
 rtl/sr_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/sr_bank_arbiter.sv | 99 +++++++++
 tb/tb_sr_bank_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared definitions for SR-flag bank blocks.
//   CMD_*        : requester command encodings, formed as {s, r}
//   idx_in_range : true when a flag index addresses an existing flag
package sr_pkg;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_CLR  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_ILL  = 2'b11;

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned nflags);
        return idx < nflags;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin winner selection with an internal rotating pointer.
//   clk        : clock, pointer updates on rising edge
//   rst        : synchronous active-low reset, pointer returns to 0
//   req_elig   : eligible requesters for this edge
//   gnt_onehot : combinational one-hot winner (zero when nothing is eligible)
// The winner is the first eligible index scanning ptr, ptr+1, ... wrapping.
// After a grant to w the pointer moves to w+1 (mod NREQ); otherwise it holds.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_elig,
    output logic [NREQ-1:0] gnt_onehot
);

    localparam int          PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned N     = NREQ;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] cand;
    int unsigned      cand_full;
    logic             found;

    always_comb begin
        gnt_onehot = '0;
        ptr_next   = ptr;
        found      = 1'b0;
        cand_full  = 0;
        cand       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand_full = (32'(ptr) + off) % N;
            cand      = PTR_W'(cand_full);
            if (!found && req_elig[cand]) begin
                found            = 1'b1;
                gnt_onehot[cand] = 1'b1;
                ptr_next         = PTR_W'((cand_full + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: shares one bank of NFLAGS set/reset flags between NREQ
// requesters, applying at most one command per cycle.
//   clk   : clock
//   rst   : synchronous active-low reset
//   req   : per-requester request, held until granted
//   s, r  : per-requester set / reset bits
//   idx   : flattened flag indices, requester i at [i*IDX_W +: IDX_W]
//   gnt   : registered one-hot grant pulse
//   err   : registered pulse when the granted command is S=R=1 or idx>=NFLAGS
//   q     : flag values
//   q_bar : ~q
module sr_bank_arbiter
    import sr_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDX_W  = $clog2(NFLAGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       s,
    input  logic [NREQ-1:0]       r,
    input  logic [NREQ*IDX_W-1:0] idx,
    output logic [NREQ-1:0]       gnt,
    output logic                  err,
    output logic [NFLAGS-1:0]     q,
    output logic [NFLAGS-1:0]     q_bar
);

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   win;
    logic              win_any;
    logic [1:0]        cmd;
    logic [IDX_W-1:0]  cmd_idx;
    logic              in_range;
    logic [NFLAGS-1:0] q_next;
    logic              err_next;

    // A requester granted in the current cycle is masked so a req that is
    // still high while gnt is visible cannot be granted twice.
    assign elig = req & ~gnt;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_elig  (elig),
        .gnt_onehot(win)
    );

    // Command mux: select the winner's {s,r} and index.
    always_comb begin
        win_any = |win;
        cmd     = CMD_HOLD;
        cmd_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                cmd     = {s[i], r[i]};
                cmd_idx = idx[i*IDX_W +: IDX_W];
            end
        end
    end

    assign in_range = idx_in_range(32'(cmd_idx), NFLAGS);

    always_comb begin
        q_next   = q;
        err_next = 1'b0;
        if (win_any) begin
            if (!in_range) begin
                err_next = 1'b1;
            end else begin
                case (cmd)
                    CMD_SET: q_next[cmd_idx] = 1'b1;
                    CMD_CLR: q_next[cmd_idx] = 1'b0;
                    CMD_ILL: err_next        = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q   <= '0;
            gnt <= '0;
            err <= 1'b0;
        end else begin
            q   <= q_next;
            gnt <= win;
            err <= err_next;
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: directed scenario bench for sr_bank_arbiter.
// Each scenario is a per-cycle table; the expected {gnt,err,q,q_bar} is
// pushed to a scoreboard queue when a row is driven and popped after the edge.
// A second NFLAGS=5 instance covers out-of-range indices, which a 3-bit index
// cannot express when NFLAGS=8.
module tb_sr_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, s, r;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic        err;
    logic [7:0]  q, q_bar;

    logic        rst5;
    logic [1:0]  req5, s5, r5;
    logic [5:0]  idx5;
    logic [1:0]  gnt5;
    logic        err5;
    logic [4:0]  q5, q_bar5;

    int checks = 0;
    int fails  = 0;

    logic [20:0] sb[$];
    logic [12:0] sb5[$];

    typedef struct {
        logic        rst;
        logic [3:0]  req, s, r;
        logic [11:0] idx;
        logic [3:0]  eg;
        logic        ee;
        logic [7:0]  eq;
    } step_t;

    typedef struct {
        logic        rst;
        logic [1:0]  req, s, r;
        logic [5:0]  idx;
        logic [1:0]  eg;
        logic        ee;
        logic [4:0]  eq;
    } step5_t;

    always #5 clk = ~clk;

    sr_bank_arbiter #(
        .NREQ(4),
        .NFLAGS(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .s(s), .r(r), .idx(idx),
        .gnt(gnt), .err(err), .q(q), .q_bar(q_bar)
    );

    sr_bank_arbiter #(
        .NREQ(2),
        .NFLAGS(5)
    ) dut5 (
        .clk(clk), .rst(rst5), .req(req5), .s(s5), .r(r5), .idx(idx5),
        .gnt(gnt5), .err(err5), .q(q5), .q_bar(q_bar5)
    );

    function automatic logic [11:0] pk(input logic [2:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic test_reset;
        step_t tbl[$];
        logic [20:0] got, e;
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0001, 1'b0, 8'h01});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h01});
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; s = tbl[i].s; r = tbl[i].r; idx = tbl[i].idx;
            sb.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt, err, q, q_bar};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_single_set_clear;
        step_t tbl[$];
        logic [20:0] got, e;
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 4'b0000, pk(3,0,0,0), 4'b0001, 1'b0, 8'h08});
        tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0001, pk(3,0,0,0), 4'b0000, 1'b0, 8'h08});
        tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0001, pk(3,0,0,0), 4'b0001, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; s = tbl[i].s; r = tbl[i].r; idx = tbl[i].idx;
            sb.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt, err, q, q_bar};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL set_clear step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_round_robin;
        step_t tbl[$];
        logic [20:0] got, e;
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0001, 1'b0, 8'h01});
        tbl.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0010, 1'b0, 8'h03});
        tbl.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0100, 1'b0, 8'h07});
        tbl.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b1000, 1'b0, 8'h0F});
        tbl.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, pk(0,1,2,3), 4'b0001, 1'b0, 8'h0F});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h0F});
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; s = tbl[i].s; r = tbl[i].r; idx = tbl[i].idx;
            sb.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt, err, q, q_bar};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL round_robin step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_illegal;
        step_t tbl[$];
        logic [20:0] got, e;
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, pk(0,0,5,0), 4'b0100, 1'b0, 8'h20});
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0100, pk(0,0,5,0), 4'b0000, 1'b0, 8'h20});
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0100, pk(0,0,5,0), 4'b0100, 1'b1, 8'h20});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h20});
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; s = tbl[i].s; r = tbl[i].r; idx = tbl[i].idx;
            sb.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt, err, q, q_bar};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL illegal step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    // The grant to requester 1 moves the pointer to 2; the reset must bring it
    // back to 0 so re-presented 1 and 3 are served in order 1 then 3.
    task automatic test_reset_mid;
        step_t tbl[$];
        logic [20:0] got, e;
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0010, 4'b0010, 4'b0000, pk(0,0,0,0), 4'b0010, 1'b0, 8'h01});
        tbl.push_back('{1'b0, 4'b1010, 4'b1010, 4'b0000, pk(0,4,0,7), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, pk(0,4,0,7), 4'b0010, 1'b0, 8'h10});
        tbl.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0000, pk(0,4,0,7), 4'b1000, 1'b0, 8'h90});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h90});
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; s = tbl[i].s; r = tbl[i].r; idx = tbl[i].idx;
            sb.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt, err, q, q_bar};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset_mid step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_same_flag_race;
        step_t tbl[$];
        logic [20:0] got, e;
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0011, 4'b0001, 4'b0010, pk(6,6,0,0), 4'b0001, 1'b0, 8'h40});
        tbl.push_back('{1'b1, 4'b0011, 4'b0001, 4'b0010, pk(6,6,0,0), 4'b0010, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0), 4'b0000, 1'b0, 8'h00});
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; s = tbl[i].s; r = tbl[i].r; idx = tbl[i].idx;
            sb.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt, err, q, q_bar};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL same_flag step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    // NFLAGS=5 instance: indices 6 and 7 are out of range and must only
    // raise err; an in-range clear right after still applies.
    task automatic test_idx_range;
        step5_t tbl[$];
        logic [12:0] got, e;
        tbl.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 6'o00, 2'b00, 1'b0, 5'h00});
        tbl.push_back('{1'b1, 2'b01, 2'b01, 2'b00, 6'o02, 2'b01, 1'b0, 5'h04});
        tbl.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 6'o00, 2'b00, 1'b0, 5'h04});
        tbl.push_back('{1'b1, 2'b01, 2'b01, 2'b00, 6'o06, 2'b01, 1'b1, 5'h04});
        tbl.push_back('{1'b1, 2'b10, 2'b00, 2'b10, 6'o70, 2'b10, 1'b1, 5'h04});
        tbl.push_back('{1'b1, 2'b10, 2'b00, 2'b10, 6'o20, 2'b00, 1'b0, 5'h04});
        tbl.push_back('{1'b1, 2'b10, 2'b00, 2'b10, 6'o20, 2'b10, 1'b0, 5'h00});
        tbl.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 6'o00, 2'b00, 1'b0, 5'h00});
        for (int i = 0; i < tbl.size(); i++) begin
            rst5 = tbl[i].rst; req5 = tbl[i].req; s5 = tbl[i].s; r5 = tbl[i].r; idx5 = tbl[i].idx;
            sb5.push_back({tbl[i].eg, tbl[i].ee, tbl[i].eq, ~tbl[i].eq});
            @(posedge clk); #1;
            got = {gnt5, err5, q5, q_bar5};
            e = sb5.pop_front();
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL idx_range step %0d: got gnt/err/q/q_bar=%h required %h", i, got, e);
            end
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; s = '0; r = '0; idx = '0;
        rst5 = 1'b0; req5 = '0; s5 = '0; r5 = '0; idx5 = '0;
        @(posedge clk); #1;
        test_reset;
        test_single_set_clear;
        test_round_robin;
        test_illegal;
        test_reset_mid;
        test_same_flag_race;
        test_idx_range;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
